// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory between the instruction-fetch
// port and the data port. One transaction runs at a time; simultaneous
// requests are resolved round-robin against the last granted port.
// Word accesses with addr[1:0] != 0 are answered with an error ack and
// never reach the memory.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_req/i_addr                  fetch request (held until i_ack)
//   i_ack/i_err/i_rdata           fetch completion pulse, misaligned flag, data
//   d_req/d_we/d_addr/d_wdata     data request (held until d_ack)
//   d_ack/d_err/d_rdata           data completion pulse, misaligned flag, load data
//   mem_en/mem_we                 memory strobe (one cycle per access), write enable
//   mem_addr/mem_wdata            memory byte address and write data
//   mem_rdata                     memory read data, valid MEM_LAT cycles after mem_en
//
// MEM_LAT must lie in 1..15 (lat_cnt is 4 bits wide).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | wait for a request, pick the winner, check alignment
// ISSUE | mem_en high for the winner's access, load the latency counter
// WAIT  | count down the memory latency, capture read data at count 1
// ACK   | completion pulse on the winner's ack (err flagged if misaligned)

module mem_port_arbiter #(
    parameter int WORD_LEN = 32,
    parameter int MEM_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [WORD_LEN-1:0] i_addr,
    output logic                i_ack,
    output logic                i_err,
    output logic [WORD_LEN-1:0] i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [WORD_LEN-1:0] d_addr,
    input  logic [WORD_LEN-1:0] d_wdata,
    output logic                d_ack,
    output logic                d_err,
    output logic [WORD_LEN-1:0] d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [WORD_LEN-1:0] mem_addr,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic [WORD_LEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t              state, state_nxt;
    logic [3:0]          lat_cnt, lat_cnt_nxt;
    logic                last_gnt, last_gnt_nxt;
    logic                gnt, gnt_nxt;

    logic                i_ack_nxt, i_err_nxt, d_ack_nxt, d_err_nxt;
    logic [WORD_LEN-1:0] i_rdata_nxt, d_rdata_nxt;
    logic                mem_en_nxt, mem_we_nxt;
    logic [WORD_LEN-1:0] mem_addr_nxt, mem_wdata_nxt;

    // Winner selection: a lone request wins; on a tie the port that was not
    // granted last time wins.
    logic                win_d;
    logic [WORD_LEN-1:0] win_addr, win_wdata;
    logic                win_we;

    assign win_d     = d_req && (!i_req || last_gnt == PORT_I);
    assign win_addr  = win_d ? d_addr : i_addr;
    assign win_we    = win_d && d_we;
    assign win_wdata = win_d ? d_wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            last_gnt  <= PORT_D;
            gnt       <= PORT_I;
            i_ack     <= 1'b0;
            i_err     <= 1'b0;
            i_rdata   <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            lat_cnt   <= lat_cnt_nxt;
            last_gnt  <= last_gnt_nxt;
            gnt       <= gnt_nxt;
            i_ack     <= i_ack_nxt;
            i_err     <= i_err_nxt;
            i_rdata   <= i_rdata_nxt;
            d_ack     <= d_ack_nxt;
            d_err     <= d_err_nxt;
            d_rdata   <= d_rdata_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
        end
    end

    // Outputs are registered, so each *_nxt value is what the output shows
    // in the state being entered: mem_en is raised on the IDLE->ISSUE
    // transition and the acks on the transition into ACK.
    always_comb begin
        state_nxt     = state;
        lat_cnt_nxt   = lat_cnt;
        last_gnt_nxt  = last_gnt;
        gnt_nxt       = gnt;
        i_ack_nxt     = 1'b0;
        i_err_nxt     = 1'b0;
        d_ack_nxt     = 1'b0;
        d_err_nxt     = 1'b0;
        i_rdata_nxt   = i_rdata;
        d_rdata_nxt   = d_rdata;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;

        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    gnt_nxt      = win_d;
                    last_gnt_nxt = win_d;
                    if (win_addr[1:0] != 2'b00) begin
                        state_nxt = ACK;
                        i_ack_nxt = !win_d;
                        i_err_nxt = !win_d;
                        d_ack_nxt = win_d;
                        d_err_nxt = win_d;
                    end else begin
                        state_nxt     = ISSUE;
                        mem_en_nxt    = 1'b1;
                        mem_we_nxt    = win_we;
                        mem_addr_nxt  = win_addr;
                        mem_wdata_nxt = win_wdata;
                    end
                end
            end
            ISSUE: begin
                lat_cnt_nxt = 4'(MEM_LAT);
                state_nxt   = WAIT;
            end
            WAIT: begin
                lat_cnt_nxt = lat_cnt - 4'd1;
                if (lat_cnt == 4'd1) begin
                    // Captured for stores too; the value is simply unused.
                    if (gnt == PORT_D) begin
                        d_rdata_nxt = mem_rdata;
                    end else begin
                        i_rdata_nxt = mem_rdata;
                    end
                    i_ack_nxt = (gnt == PORT_I);
                    d_ack_nxt = (gnt == PORT_D);
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
